// File: rtl/fifo_rd_ptr_ctrl_pkg.sv
// Shared definitions for the async FIFO pointer controllers (read and write side).
package fifo_rd_ptr_ctrl_pkg;

    localparam int FIFO_AW_DEFAULT   = 4;
    localparam int FIFO_SYNC_DEFAULT = 2;

    // Pointers carry one bit beyond the RAM address to tell full from empty.
    function automatic int fifo_ptr_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_gray_conv.sv
// Binary/gray pointer converters shared by both FIFO pointer controllers.
module fifo_bin2gray #(
    parameter int DW = 5
) (
    input  logic [DW-1:0] bin,
    output logic [DW-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

module fifo_gray2bin #(
    parameter int DW = 5
) (
    input  logic [DW-1:0] gray,
    output logic [DW-1:0] bin
);
    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < DW; i++) begin
            bin[i] = ^(gray >> i);
        end
    end
endmodule

// File: rtl/fifo_sync_chain.sv
// Multi-flop synchronizer for a gray-coded pointer crossing into this clock domain.
module fifo_sync_chain #(
    parameter int W     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer controller: syncs the write pointer, tracks the read pointer,
// and derives empty, fill count and underflow.
module fifo_rd_ptr_ctrl
    import fifo_rd_ptr_ctrl_pkg::*;
#(
    parameter int AW          = FIFO_AW_DEFAULT,
    parameter int SYNC_STAGES = FIFO_SYNC_DEFAULT,
    localparam int PW         = fifo_ptr_width(AW)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          rd_en,
    input  logic [PW-1:0] wr_gray_async,
    output logic [AW-1:0] rd_addr,
    output logic [PW-1:0] rd_gray,
    output logic          empty,
    output logic [PW-1:0] rd_count,
    output logic          underflow
);
    logic [PW-1:0] wr_gray_sync;
    logic [PW-1:0] wr_bin_sync;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic          rd_inc;

    fifo_sync_chain #(.W(PW), .DEPTH(SYNC_STAGES)) u_wr_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      (wr_gray_async),
        .q      (wr_gray_sync)
    );

    fifo_gray2bin #(.DW(PW)) u_wr_g2b (
        .gray (wr_gray_sync),
        .bin  (wr_bin_sync)
    );

    assign rd_inc      = rd_en & ~empty;
    assign rd_bin_next = rd_bin + PW'(rd_inc);

    fifo_bin2gray #(.DW(PW)) u_rd_b2g (
        .bin  (rd_bin_next),
        .gray (rd_gray_next)
    );

    // Empty and count look at the next pointer so the last read is reflected at once.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            rd_bin    <= '0;
            rd_gray   <= '0;
            empty     <= 1'b1;
            rd_count  <= '0;
            underflow <= 1'b0;
        end else begin
            rd_bin    <= rd_bin_next;
            rd_gray   <= rd_gray_next;
            empty     <= (rd_gray_next == wr_gray_sync);
            rd_count  <= wr_bin_sync - rd_bin_next;
            underflow <= rd_en & empty;
        end
    end

    assign rd_addr = rd_bin[AW-1:0];
endmodule
